// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_controller_pkg;

  localparam int unsigned SRAM_DW = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage : sram_controller_pkg

// File: rtl/sram_controller.sv
// Splits one 32-bit MEM-stage access into two 16-bit asynchronous SRAM phases,
// each held for WAIT_CYCLES cycles; ready stays low until the access finishes.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_wr_q;
  logic [ADDR_W-2:0]    idx_q;
  logic [31:0]          wdata_q;
  logic [SRAM_DW-1:0]   rd_lo_q;
  logic [31:0]          rdata_q;
  logic [ADDR_W-1:0]    sram_addr_q;

  logic                 req;
  logic                 phase_end;
  logic [ADDR_W-2:0]    req_idx;

  assign req       = mem_r_en | mem_w_en;
  assign phase_end = (cnt_q == CNT_LAST);
  // Addresses below BASE_ADDR or beyond the SRAM wrap modulo its size.
  assign req_idx   = (ADDR_W-1)'((addr - BASE_ADDR) >> 2);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready       = 1'b1;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = '0;

    unique case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_d = LOW;
          cnt_d   = '0;
        end
      end
      LOW: begin
        ready       = 1'b0;
        sram_we_n   = ~op_wr_q;
        sram_dq_oe  = op_wr_q;
        sram_dq_out = op_wr_q ? wdata_q[15:0] : '0;
        if (phase_end) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        ready       = 1'b0;
        sram_we_n   = ~op_wr_q;
        sram_dq_oe  = op_wr_q;
        sram_dq_out = op_wr_q ? wdata_q[31:16] : '0;
        if (phase_end) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rd_lo_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        op_wr_q     <= mem_w_en;
        idx_q       <= req_idx;
        wdata_q     <= wdata;
        sram_addr_q <= {req_idx, 1'b0};
      end
      if (state_q == LOW && phase_end) begin
        sram_addr_q <= {idx_q, 1'b1};
        if (!op_wr_q) rd_lo_q <= sram_dq_in;
      end
      // The low half is staged so rdata only ever changes as a whole word.
      if (state_q == HIGH && phase_end && !op_wr_q) begin
        rdata_q <= {sram_dq_in, rd_lo_q};
      end
    end
  end

  assign rdata     = rdata_q;
  assign sram_addr = sram_addr_q;

endmodule : sram_controller

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM model.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic [15:0] mem [0:(1<<18)-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_controller #(.ADDR_W(18), .WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  assign sram_dq_in = mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one request starting now (state IDLE) and checks all 6 cycles.
  // The request stays asserted through DONE, as a frozen pipeline would hold it.
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [17:0] exp_base, input logic exp_wr,
                        input logic [31:0] exp_rdata);
    mem_r_en = r;
    mem_w_en = w;
    addr     = a;
    wdata    = d;
    #1;
    check({tag, " c0 ready"}, 32'(ready), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (c == 1) begin
        addr  = 32'h0BAD_0000;
        wdata = 32'h5A5A_A5A5;
        #1;
      end
      if (c < 5) begin
        check($sformatf("%s c%0d ready", tag, c), 32'(ready), 32'd0);
        check($sformatf("%s c%0d addr", tag, c), 32'(sram_addr),
              32'(exp_base) + ((c > 2) ? 32'd1 : 32'd0));
        check($sformatf("%s c%0d we_n", tag, c), 32'(sram_we_n), 32'(!exp_wr));
        check($sformatf("%s c%0d oe", tag, c), 32'(sram_dq_oe), 32'(exp_wr));
        if (exp_wr)
          check($sformatf("%s c%0d dq", tag, c), 32'(sram_dq_out),
                (c > 2) ? 32'(d[31:16]) : 32'(d[15:0]));
      end else begin
        check({tag, " done ready"}, 32'(ready), 32'd1);
        check({tag, " done we_n"}, 32'(sram_we_n), 32'd1);
        check({tag, " done oe"}, 32'(sram_dq_oe), 32'd0);
        check({tag, " done rdata"}, rdata, exp_rdata);
      end
    end
  endtask

  task automatic go_idle();
    next_cycle();
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    #1;
    check("idle ready", 32'(ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << 18); i++) mem[i] = 16'h0000;
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst ready", 32'(ready), 32'd1);
    check("rst we_n", 32'(sram_we_n), 32'd1);
    check("rst oe", 32'(sram_dq_oe), 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst addr", 32'(sram_addr), 32'd0);
    check("rst dq", 32'(sram_dq_out), 32'd0);

    // Word 2 -> halfwords 4/5.
    next_cycle();
    access("wr1", 1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 18'd4, 1'b1, 32'd0);
    go_idle();
    check("mem4", 32'(mem[4]), 32'h0000_BEEF);
    check("mem5", 32'(mem[5]), 32'h0000_DEAD);

    next_cycle();
    access("rd1", 1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 1'b0, 32'hDEAD_BEEF);
    go_idle();

    // Both enables: treated as write to word 3, rdata untouched.
    next_cycle();
    access("both", 1'b1, 1'b1, 32'd1036, 32'h1234_5678, 18'd6, 1'b1, 32'hDEAD_BEEF);
    go_idle();
    next_cycle();
    access("rd2", 1'b1, 1'b0, 32'd1036, 32'd0, 18'd6, 1'b0, 32'h1234_5678);
    go_idle();

    // Below BASE_ADDR wraps to the top word; low address bits are ignored.
    next_cycle();
    access("wrap", 1'b0, 1'b1, 32'd1020, 32'hCAFE_F00D, 18'h3FFFE, 1'b1, 32'h1234_5678);
    go_idle();
    next_cycle();
    access("rdwrap", 1'b1, 1'b0, 32'd1023, 32'd0, 18'h3FFFE, 1'b0, 32'hCAFE_F00D);
    go_idle();
    // 1024 + 4*2^17 wraps to word 0.
    next_cycle();
    access("rdhi", 1'b1, 1'b0, 32'd525312, 32'd0, 18'd0, 1'b0, 32'h0000_0000);
    go_idle();

    // Reset during the last LOW cycle of a write to word 4 (halfwords 8/9).
    next_cycle();
    mem_w_en = 1'b1; addr = 32'd1040; wdata = 32'hAAAA_5555;
    #1;
    check("rstmid c0 ready", 32'(ready), 32'd0);
    next_cycle();
    check("rstmid c1 we_n", 32'(sram_we_n), 32'd0);
    check("rstmid c1 addr", 32'(sram_addr), 32'd8);
    next_cycle();
    rst = 1'b1; mem_w_en = 1'b0;
    next_cycle();
    check("rstmid we_n", 32'(sram_we_n), 32'd1);
    check("rstmid oe", 32'(sram_dq_oe), 32'd0);
    check("rstmid ready", 32'(ready), 32'd1);
    check("rstmid addr", 32'(sram_addr), 32'd0);
    rst = 1'b0;
    check("rstmid mem9", 32'(mem[9]), 32'd0);
    next_cycle();
    access("rdmid", 1'b1, 1'b0, 32'd1040, 32'd0, 18'd8, 1'b0, 32'h0000_5555);
    go_idle();

    // Back-to-back: the read begins the cycle right after the write's DONE.
    next_cycle();
    access("b2b_wr", 1'b0, 1'b1, 32'd1044, 32'h0BAD_C0DE, 18'd10, 1'b1, 32'h0000_5555);
    next_cycle();
    access("b2b_rd", 1'b1, 1'b0, 32'd1044, 32'd0, 18'd10, 1'b0, 32'h0BAD_C0DE);
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sram_controller
